// File: rtl/fnd_digit_driver.sv
// fnd_digit_driver
// Drives a 4-digit common-anode FND from a free-running 2-bit digit select.
// A 14-bit binary value is accepted over valid/ready, converted to BCD with an
// iterative double-dabble FSM (14 shift cycles plus one load cycle), and held
// in a display register. Anodes are blanked for BLANK_CYCLES after every
// digit-select change to suppress ghosting.
// Optional build macro: FND_LEADING_ZERO_BLANK_EN -- when defined, digits above
// the most significant nonzero digit are blanked (value 0 shows a single "0").
module fnd_digit_driver #(
  parameter int BLANK_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_digit_sel,
  input  logic [13:0] i_value,
  input  logic        i_value_valid,
  output logic        o_ready,
  output logic        o_ovf,
  output logic [3:0]  o_an,
  output logic [7:0]  o_seg
);

  localparam int CNT_W = $clog2(BLANK_CYCLES + 2);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  logic [1:0]       state;
  logic [13:0]      bin_q;
  logic [15:0]      bcd_q;
  logic [15:0]      bcd_adj;
  logic [3:0]       bit_cnt;
  logic             ovf_pend;
  logic [15:0]      disp_q;
  logic [1:0]       sel_q;
  logic [CNT_W-1:0] blank_cnt;
  logic [CNT_W-1:0] blank_next;
  logic             sel_change;
  logic [3:0]       digit_val;
  logic             digit_show;
  logic [7:0]       seg_next;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  assign o_ready = (state == ST_IDLE);

  // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Converter FSM: capture (clamped) value, shift 14 times, then publish to the display
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      bit_cnt  <= '0;
      ovf_pend <= 1'b0;
      disp_q   <= '0;
      o_ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_value_valid) begin
            bin_q    <= (i_value > 14'd9999) ? 14'd9999 : i_value;
            ovf_pend <= (i_value > 14'd9999);
            bcd_q    <= '0;
            bit_cnt  <= '0;
            state    <= ST_CONV;
          end
        end
        ST_CONV: begin
          {bcd_q, bin_q} <= {bcd_adj[14:0], bin_q, 1'b0};
          if (bit_cnt == 4'd13) begin
            state <= ST_LOAD;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        ST_LOAD: begin
          disp_q <= bcd_q;
          o_ovf  <= ovf_pend;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Segment pattern for the currently registered digit, including leading-zero and dp handling
  always_comb begin
    digit_val  = 4'd0;
    digit_show = 1'b1;
    case (sel_q)
      2'd0: digit_val = disp_q[3:0];
      2'd1: digit_val = disp_q[7:4];
      2'd2: digit_val = disp_q[11:8];
      default: digit_val = disp_q[15:12];
    endcase
`ifdef FND_LEADING_ZERO_BLANK_EN
    case (sel_q)
      2'd0: digit_show = 1'b1;
      2'd1: digit_show = (disp_q[15:4] != 12'd0);
      2'd2: digit_show = (disp_q[15:8] != 8'd0);
      default: digit_show = (disp_q[15:12] != 4'd0);
    endcase
`endif
    seg_next = digit_show ? seg_decode(digit_val) : 8'hFF;
    if ((sel_q == 2'd3) && o_ovf) begin
      seg_next[7] = 1'b0;
    end
  end

  assign sel_change = (i_digit_sel != sel_q);
  assign blank_next = (blank_cnt != '0) ? (blank_cnt - 1'b1) : '0;

  // Scan output stage: track the select, blank on every change, then light one anode
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sel_q     <= 2'd0;
      blank_cnt <= '0;
      o_an      <= 4'hF;
      o_seg     <= 8'hFF;
    end else if (sel_change) begin
      sel_q     <= i_digit_sel;
      blank_cnt <= BLANK_LOAD;
      o_an      <= 4'hF;
      o_seg     <= 8'hFF;
    end else begin
      blank_cnt <= blank_next;
      if (blank_next != '0) begin
        o_an  <= 4'hF;
        o_seg <= 8'hFF;
      end else begin
        o_an  <= ~(4'b0001 << sel_q);
        o_seg <= seg_next;
      end
    end
  end

endmodule

// File: tb/tb_fnd_digit_driver.sv
// tb_fnd_digit_driver
// Scoreboard bench for fnd_digit_driver: each accepted value pushes its
// expected display contents; the entry is popped and checked when o_ready
// returns, then every digit is scanned and its anode/segment code compared.
module tb_fnd_digit_driver;

  localparam int BLANK = 4;

  typedef struct {
    int val;
    bit ovf;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [1:0]  i_digit_sel;
  logic [13:0] i_value;
  logic        i_value_valid;
  logic        o_ready;
  logic        o_ovf;
  logic [3:0]  o_an;
  logic [7:0]  o_seg;

  int   testsRun = 0;
  int   testsFailed = 0;
  int   curVal = 0;
  bit   curOvf = 1'b0;
  int   curSel = 0;
  exp_t sb[$];

  fnd_digit_driver #(.BLANK_CYCLES(BLANK)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_digit_sel   (i_digit_sel),
    .i_value       (i_value),
    .i_value_valid (i_value_valid),
    .o_ready       (o_ready),
    .o_ovf         (o_ovf),
    .o_an          (o_an),
    .o_seg         (o_seg)
  );

  // Free-running system clock
  always #5 i_clk = ~i_clk;

  // Hard stop in case something wedges outside the bounded waits
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] expSeg(input int val, input bit ovf, input int d);
    int div;
    int dig;
    logic [7:0] s;
    div = (d == 0) ? 1 : (d == 1) ? 10 : (d == 2) ? 100 : 1000;
    dig = (val / div) % 10;
    case (dig)
      0: s = 8'hC0;
      1: s = 8'hF9;
      2: s = 8'hA4;
      3: s = 8'hB0;
      4: s = 8'h99;
      5: s = 8'h92;
      6: s = 8'h82;
      7: s = 8'hF8;
      8: s = 8'h80;
      9: s = 8'h90;
      default: s = 8'hFF;
    endcase
`ifdef FND_LEADING_ZERO_BLANK_EN
    if (d > 0 && val < div) s = 8'hFF;
`endif
    if (d == 3 && ovf) s[7] = 1'b0;
    return s;
  endfunction

  // Move the scan to digit d, measure the blank window, then check the lit digit
  task automatic selectDigit(input int d);
    int blanks;
    int expBlanks;
    bit done;
    logic [3:0] expAn;
    expBlanks = (d != curSel) ? ((BLANK > 0) ? BLANK : 1) : 0;
    expAn = ~(4'b0001 << d);
    i_digit_sel = 2'(d);
    blanks = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      if (o_an == 4'hF) blanks++;
      else done = 1'b1;
    end
    curSel = d;
    checkOutput("blankCycles", blanks, expBlanks);
    checkOutput("anode", o_an, expAn);
    checkOutput("segment", o_seg, expSeg(curVal, curOvf, d));
  endtask

  task automatic scanAll();
    for (int d = 0; d < 4; d++) selectDigit(d);
  endtask

  // Offer a value once the converter is idle and record what it should display
  task automatic applyStimulus(input int v);
    exp_t e;
    for (int k = 0; k < 50 && !o_ready; k++) tick();
    checkOutput("readyBeforeAccept", o_ready, 1);
    i_value = 14'(v);
    i_value_valid = 1'b1;
    tick();
    i_value_valid = 1'b0;
    checkOutput("busyAfterAccept", o_ready, 0);
    e.val = (v > 9999) ? 9999 : v;
    e.ovf = (v > 9999);
    sb.push_back(e);
  endtask

  // Wait for conversion end, checking the old value stays shown; optionally inject an ignored valid
  task automatic waitResult(input int intrudeAt, input int intrudeVal);
    int lat;
    exp_t e;
    lat = -1;
    for (int t = 1; t <= 40 && lat < 0; t++) begin
      tick();
      i_value_valid = 1'b0;
      checkOutput("holdOldDisplay", o_seg, expSeg(curVal, curOvf, curSel));
      if (o_ready) lat = t;
      else if (t == intrudeAt) begin
        i_value = 14'(intrudeVal);
        i_value_valid = 1'b1;
      end
    end
    i_value_valid = 1'b0;
    checkOutput("latency", lat, 15);
    if (sb.size() == 0) begin
      checkOutput("scoreboardEmpty", 0, 1);
    end else begin
      e = sb.pop_front();
      checkOutput("ovf", o_ovf, e.ovf);
      curVal = e.val;
      curOvf = e.ovf;
      tick();
      checkOutput("newSegment", o_seg, expSeg(curVal, curOvf, curSel));
      scanAll();
    end
  endtask

  task automatic convert(input int v);
    applyStimulus(v);
    waitResult(-1, 0);
  endtask

  initial begin
    i_reset = 1'b1;
    i_digit_sel = 2'd0;
    i_value = '0;
    i_value_valid = 1'b0;
    tick();
    tick();
    checkOutput("resetReady", o_ready, 1);
    checkOutput("resetOvf", o_ovf, 0);
    checkOutput("resetAnode", o_an, 4'hF);
    checkOutput("resetSegment", o_seg, 8'hFF);
    i_reset = 1'b0;

    // Scan with nothing loaded: all zeros
    scanAll();

    // Basic conversions, clamp/overflow and boundaries
    convert(1234);
    convert(12000);
    applyStimulus(1234);
    waitResult(5, 5678);
    convert(5678);
    convert(9999);
    convert(10000);
    convert(16383);
    convert(0);
    convert(42);

    // Reset in the middle of a conversion
    applyStimulus(1234);
    repeat (6) tick();
    i_reset = 1'b1;
    i_digit_sel = 2'd0;
    tick();
    checkOutput("midResetReady", o_ready, 1);
    checkOutput("midResetAnode", o_an, 4'hF);
    checkOutput("midResetSegment", o_seg, 8'hFF);
    checkOutput("midResetOvf", o_ovf, 0);
    i_reset = 1'b0;
    sb.delete();
    curVal = 0;
    curOvf = 1'b0;
    curSel = 0;
    scanAll();

    // Two select changes back to back: the blank window restarts from the last one
    convert(8765);
    i_digit_sel = 2'd1;
    tick();
    checkOutput("doubleChangeBlank", o_an, 4'hF);
    curSel = 1;
    selectDigit(2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
